// File: rtl/garbage_lines_manager_pkg.sv
// -----------------------------------------------------------------------------
// garbage_lines_manager_pkg
//   Shared constants and helpers for the garbage/line bookkeeping block:
//   base attack tables (normal and T-spin), the combo bonus curve, the
//   default rise limit and a population-count helper for the line-full vector.
// -----------------------------------------------------------------------------
package garbage_lines_manager_pkg;

   // Largest number of garbage rows inserted by a single rise event.
   localparam int MAX_RISE_DEFAULT = 8;

   // Base attack indexed by rows cleared (0..4).
   localparam logic [2:0] ATTACK_BASE [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4};

   // T-spin base attack indexed by rows cleared (0..3).
   localparam logic [2:0] TSPIN_BASE [4] = '{3'd0, 3'd2, 3'd4, 3'd6};

   // Number of set bits; callers zero-extend narrower vectors to 64 bits.
   function automatic int unsigned count_set_bits(input logic [63:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         cnt += 32'(v[i]);
      end
      return cnt;
   endfunction

   // Extra rows sent for being deep in a combo chain (combo 0 = first clear).
   function automatic int unsigned combo_bonus(input int unsigned c);
      if (c < 2)       return 0;
      else if (c < 4)  return 1;
      else if (c < 6)  return 2;
      else if (c < 8)  return 3;
      else if (c < 11) return 4;
      else             return 5;
   endfunction

endpackage

// File: rtl/garbage_lines_manager_attack_calc.sv
// -----------------------------------------------------------------------------
// garbage_lines_manager_attack_calc
//   Purely combinational attack evaluation for one lock.
//   Config macro: TSPIN_ATTACK_EN -- when defined, tspin selects the T-spin
//   base table and makes any clearing T-spin "difficult"; otherwise tspin
//   is ignored.
// Ports
//   n           in   3        rows cleared by the lock, already clamped to 0..4
//   tspin       in   1        lock was a T-spin
//   combo       in   COMBO_W  combo value the lock will produce
//   b2b_active  in   1        previous clearing lock was difficult
//   attack      out  ATK_W    base + back-to-back + combo bonus, saturated
//   difficult   out  1        this lock keeps/starts a back-to-back chain
// -----------------------------------------------------------------------------
module garbage_lines_manager_attack_calc
   import garbage_lines_manager_pkg::*;
#(
   parameter int COMBO_W = 5,
   parameter int ATK_W   = 5
) (
   input  logic [2:0]         n,
   input  logic               tspin,
   input  logic [COMBO_W-1:0] combo,
   input  logic               b2b_active,
   output logic [ATK_W-1:0]   attack,
   output logic               difficult
);

   localparam int unsigned ATK_MAX = (1 << ATK_W) - 1;

   int unsigned base;
   int unsigned sum;

`ifndef TSPIN_ATTACK_EN
   logic unused_tspin;
   assign unused_tspin = tspin;
`endif

   // NOTE: every variable written here gets a value before any branch so the
   // block stays purely combinational instead of inferring latches.
   always_comb begin
      base      = 32'(ATTACK_BASE[n]);
      difficult = (n == 3'd4);
`ifdef TSPIN_ATTACK_EN
      if (tspin && (n != 3'd0)) begin
         difficult = 1'b1;
         if (n != 3'd4) begin
            base = 32'(TSPIN_BASE[n[1:0]]);
         end
      end
`endif
      sum = base + ((difficult && b2b_active) ? 32'd1 : 32'd0)
                 + combo_bonus(32'(combo));
      attack = (sum > ATK_MAX) ? ATK_W'(ATK_MAX) : ATK_W'(sum);
   end

endmodule

// File: rtl/garbage_lines_manager.sv
// -----------------------------------------------------------------------------
// garbage_lines_manager
//   Per-player line/attack bookkeeping. On each lock it counts cleared rows,
//   advances combo and back-to-back state, turns the clear into outgoing
//   garbage, cancels that against queued incoming garbage and either offers
//   the remainder to the link or (on a non-clearing lock) raises queued
//   garbage into the playfield. All outputs are registered.
//   Config macro: TSPIN_ATTACK_EN (forwarded to the attack calculator).
// Ports
//   clk, rst_l            clock, synchronous active-low reset
//   game_start            synchronous clear of all state, dominates other inputs
//   lock_valid            piece locked; lines_full/tspin valid
//   lines_full[ROWS]      per-row full flags at lock
//   tspin                 lock was a T-spin
//   garb_in_valid/count   incoming opponent garbage rows
//   send_valid/count      outgoing garbage offer; send_ready completes transfer
//   rise_valid/count      one-cycle request to insert rise_count rows
//   pending_garbage       queued incoming rows
//   lines_cleared/sent    game totals (saturating)
//   combo, combo_active   combo chain state
//   b2b_active            last clearing lock was difficult
// -----------------------------------------------------------------------------
module garbage_lines_manager
   import garbage_lines_manager_pkg::*;
#(
   parameter int ROWS     = 20,
   parameter int CNT_W    = 10,
   parameter int COMBO_W  = 5,
   parameter int ATK_W    = 5,
   parameter int MAX_RISE = MAX_RISE_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic               game_start,
   input  logic               lock_valid,
   input  logic [ROWS-1:0]    lines_full,
   input  logic               tspin,
   input  logic               garb_in_valid,
   input  logic [ATK_W-1:0]   garb_in_count,
   output logic               send_valid,
   output logic [ATK_W-1:0]   send_count,
   input  logic               send_ready,
   output logic               rise_valid,
   output logic [ATK_W-1:0]   rise_count,
   output logic [ATK_W-1:0]   pending_garbage,
   output logic [CNT_W-1:0]   lines_cleared,
   output logic [CNT_W-1:0]   lines_sent,
   output logic [COMBO_W-1:0] combo,
   output logic               combo_active,
   output logic               b2b_active
);

   localparam logic [ATK_W-1:0] RISE_LIMIT = ATK_W'(MAX_RISE);

   int unsigned        n_raw;
   logic [2:0]         n;
   logic [COMBO_W-1:0] new_combo;
   logic [ATK_W-1:0]   attack;
   logic               difficult;

   logic [ATK_W-1:0]   cancel;
   logic [ATK_W-1:0]   out_rows;
   logic [ATK_W-1:0]   rise_rows;
   logic [ATK_W-1:0]   held;
   logic [ATK_W:0]     pend_wide;
   logic [ATK_W:0]     send_sum;
   logic [CNT_W:0]     clr_sum;
   logic [CNT_W:0]     sent_sum;

   logic               send_valid_d;
   logic [ATK_W-1:0]   send_count_d;
   logic               rise_valid_d;
   logic [ATK_W-1:0]   rise_count_d;
   logic [ATK_W-1:0]   pending_d;
   logic [CNT_W-1:0]   lines_cleared_d;
   logic [CNT_W-1:0]   lines_sent_d;
   logic [COMBO_W-1:0] combo_d;
   logic               combo_active_d;
   logic               b2b_active_d;

   // Row count clamped to a tetris, and the combo value this lock would reach.
   always_comb begin
      n_raw     = count_set_bits(64'(lines_full));
      n         = (n_raw > 4) ? 3'd4 : 3'(n_raw);
      new_combo = combo_active ? ((combo == '1) ? combo : combo + COMBO_W'(1))
                               : '0;
   end

   garbage_lines_manager_attack_calc #(
      .COMBO_W (COMBO_W),
      .ATK_W   (ATK_W)
   ) u_attack_calc (
      .n          (n),
      .tspin      (tspin),
      .combo      (new_combo),
      .b2b_active (b2b_active),
      .attack     (attack),
      .difficult  (difficult)
   );

   always_comb begin
      send_valid_d    = send_valid;
      send_count_d    = send_count;
      rise_valid_d    = 1'b0;
      rise_count_d    = '0;
      lines_cleared_d = lines_cleared;
      lines_sent_d    = lines_sent;
      combo_d         = combo;
      combo_active_d  = combo_active;
      b2b_active_d    = b2b_active;
      cancel          = '0;
      out_rows        = '0;
      rise_rows       = '0;
      clr_sum         = {1'b0, lines_cleared} + (CNT_W+1)'(n);
      sent_sum        = '0;

      if (lock_valid) begin
         if (n == 3'd0) begin
            combo_d        = '0;
            combo_active_d = 1'b0;
            if (pending_garbage != '0) begin
               rise_rows    = (pending_garbage < RISE_LIMIT) ? pending_garbage : RISE_LIMIT;
               rise_valid_d = 1'b1;
               rise_count_d = rise_rows;
            end
         end else begin
            combo_d         = new_combo;
            combo_active_d  = 1'b1;
            b2b_active_d    = difficult;
            cancel          = (attack < pending_garbage) ? attack : pending_garbage;
            out_rows        = attack - cancel;
            lines_cleared_d = clr_sum[CNT_W] ? '1 : clr_sum[CNT_W-1:0];
            sent_sum        = {1'b0, lines_sent} + (CNT_W+1)'(out_rows);
            lines_sent_d    = sent_sum[CNT_W] ? '1 : sent_sum[CNT_W-1:0];
         end
      end

      // Lock consumes the pre-cycle queue first; new arrivals land afterwards.
      // cancel and rise never exceed the queue, so only the add can overflow.
      pend_wide = {1'b0, pending_garbage} - {1'b0, cancel} - {1'b0, rise_rows}
                + (garb_in_valid ? {1'b0, garb_in_count} : '0);
      pending_d = pend_wide[ATK_W] ? '1 : pend_wide[ATK_W-1:0];

      // An offer the link has not taken yet is merged with the new rows.
      held     = (send_valid && !send_ready) ? send_count : '0;
      send_sum = {1'b0, held} + {1'b0, out_rows};
      if (out_rows != '0) begin
         send_valid_d = 1'b1;
         send_count_d = send_sum[ATK_W] ? '1 : send_sum[ATK_W-1:0];
      end else if (send_valid && send_ready) begin
         send_valid_d = 1'b0;
         send_count_d = '0;
      end

      if (game_start) begin
         send_valid_d    = 1'b0;
         send_count_d    = '0;
         rise_valid_d    = 1'b0;
         rise_count_d    = '0;
         pending_d       = '0;
         lines_cleared_d = '0;
         lines_sent_d    = '0;
         combo_d         = '0;
         combo_active_d  = 1'b0;
         b2b_active_d    = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         send_valid      <= 1'b0;
         send_count      <= '0;
         rise_valid      <= 1'b0;
         rise_count      <= '0;
         pending_garbage <= '0;
         lines_cleared   <= '0;
         lines_sent      <= '0;
         combo           <= '0;
         combo_active    <= 1'b0;
         b2b_active      <= 1'b0;
      end else begin
         send_valid      <= send_valid_d;
         send_count      <= send_count_d;
         rise_valid      <= rise_valid_d;
         rise_count      <= rise_count_d;
         pending_garbage <= pending_d;
         lines_cleared   <= lines_cleared_d;
         lines_sent      <= lines_sent_d;
         combo           <= combo_d;
         combo_active    <= combo_active_d;
         b2b_active      <= b2b_active_d;
      end
   end

endmodule

// File: tb/tb_garbage_lines_manager.sv
// -----------------------------------------------------------------------------
// tb_garbage_lines_manager
//   Self-checking bench for garbage_lines_manager. Each scenario task queues
//   stimulus together with the expected registered outputs, then drains the
//   queue one clock at a time and compares what the design produced.
// -----------------------------------------------------------------------------
module tb_garbage_lines_manager;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        game_start;
   logic        lock_valid;
   logic [19:0] lines_full;
   logic        tspin;
   logic        garb_in_valid;
   logic [4:0]  garb_in_count;
   logic        send_valid;
   logic [4:0]  send_count;
   logic        send_ready;
   logic        rise_valid;
   logic [4:0]  rise_count;
   logic [4:0]  pending_garbage;
   logic [9:0]  lines_cleared;
   logic [9:0]  lines_sent;
   logic [4:0]  combo;
   logic        combo_active;
   logic        b2b_active;

   garbage_lines_manager dut (
      .clk             (clk),
      .rst_l           (rst_l),
      .game_start      (game_start),
      .lock_valid      (lock_valid),
      .lines_full      (lines_full),
      .tspin           (tspin),
      .garb_in_valid   (garb_in_valid),
      .garb_in_count   (garb_in_count),
      .send_valid      (send_valid),
      .send_count      (send_count),
      .send_ready      (send_ready),
      .rise_valid      (rise_valid),
      .rise_count      (rise_count),
      .pending_garbage (pending_garbage),
      .lines_cleared   (lines_cleared),
      .lines_sent      (lines_sent),
      .combo           (combo),
      .combo_active    (combo_active),
      .b2b_active      (b2b_active)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       sv;
      logic [4:0] sc;
      logic [4:0] pend;
      logic       rv;
      logic [4:0] rc;
      logic [4:0] combo;
      logic       cact;
      logic       b2b;
   } exp_t;

   typedef struct packed {
      logic        gs;
      logic        lock;
      logic [19:0] lines;
      logic        tsp;
      logic        gv;
      logic [4:0]  gc;
      logic        ready;
   } stim_t;

   int total = 0;
   int bad   = 0;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   exp_t  obs;
   exp_t  e;
   stim_t s;

   always_comb begin
      obs       = '0;
      obs.sv    = send_valid;
      obs.sc    = send_count;
      obs.pend  = pending_garbage;
      obs.rv    = rise_valid;
      obs.rc    = rise_count;
      obs.combo = combo;
      obs.cact  = combo_active;
      obs.b2b   = b2b_active;
   end

   function automatic exp_t ex(input int sv, input int sc, input int pend, input int rv,
                               input int rc, input int cmb, input int cact, input int b2b);
      exp_t r;
      r.sv    = 1'(sv);
      r.sc    = 5'(sc);
      r.pend  = 5'(pend);
      r.rv    = 1'(rv);
      r.rc    = 5'(rc);
      r.combo = 5'(cmb);
      r.cact  = 1'(cact);
      r.b2b   = 1'(b2b);
      return r;
   endfunction

   function automatic stim_t st(input int gs, input int lock, input int lines, input int tsp,
                                input int gv, input int gc, input int ready);
      stim_t r;
      r.gs    = 1'(gs);
      r.lock  = 1'(lock);
      r.lines = 20'(lines);
      r.tsp   = 1'(tsp);
      r.gv    = 1'(gv);
      r.gc    = 5'(gc);
      r.ready = 1'(ready);
      return r;
   endfunction

   task automatic add(input stim_t si, input exp_t ei);
      stim_q.push_back(si);
      exp_q.push_back(ei);
   endtask

   // One clock: apply stimulus, let the edge capture it, sample 1 ns later.
   task automatic drive(input stim_t si);
      game_start    = si.gs;
      lock_valid    = si.lock;
      lines_full    = si.lines;
      tspin         = si.tsp;
      garb_in_valid = si.gv;
      garb_in_count = si.gc;
      send_ready    = si.ready;
      @(posedge clk);
      #1;
      game_start    = 1'b0;
      lock_valid    = 1'b0;
      lines_full    = '0;
      tspin         = 1'b0;
      garb_in_valid = 1'b0;
      garb_in_count = '0;
   endtask

   task automatic show_fail(input string name, input int idx);
      $display("FAIL %s[%0d]: got sv=%0b sc=%0d pend=%0d rv=%0b rc=%0d combo=%0d cact=%0b b2b=%0b | want sv=%0b sc=%0d pend=%0d rv=%0b rc=%0d combo=%0d cact=%0b b2b=%0b",
               name, idx, obs.sv, obs.sc, obs.pend, obs.rv, obs.rc, obs.combo, obs.cact, obs.b2b,
               e.sv, e.sc, e.pend, e.rv, e.rc, e.combo, e.cact, e.b2b);
   endtask

   task automatic test_reset();
      rst_l         = 1'b0;
      game_start    = 1'b0;
      lock_valid    = 1'b1;
      lines_full    = 20'hF;
      tspin         = 1'b0;
      garb_in_valid = 1'b1;
      garb_in_count = 5'd5;
      send_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      e = ex(0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs !== e) begin bad++; show_fail("reset_outputs", 0); end
      total++;
      if (lines_cleared !== 10'd0) begin bad++; $display("FAIL reset_lines_cleared: got %0d want 0", lines_cleared); end
      total++;
      if (lines_sent !== 10'd0) begin bad++; $display("FAIL reset_lines_sent: got %0d want 0", lines_sent); end
      lock_valid    = 1'b0;
      lines_full    = '0;
      garb_in_valid = 1'b0;
      garb_in_count = '0;
      rst_l         = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_base_attack();
      add(st(0, 1, 'h1, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 1, 0));
      add(st(0, 1, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
      add(st(0, 1, 'h3, 0, 0, 0, 1), ex(1, 1, 0, 0, 0, 0, 1, 0));
      add(st(0, 1, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
      add(st(0, 1, 'h7, 0, 0, 0, 1), ex(1, 2, 0, 0, 0, 0, 1, 0));
      add(st(0, 1, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
      add(st(0, 1, 'hF, 0, 0, 0, 1), ex(1, 4, 0, 0, 0, 0, 1, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("base_attack", i); end
      end
      total++;
      if (lines_cleared !== 10'd10) begin bad++; $display("FAIL base_lines_cleared: got %0d want 10", lines_cleared); end
      total++;
      if (lines_sent !== 10'd7) begin bad++; $display("FAIL base_lines_sent: got %0d want 7", lines_sent); end
   endtask

   task automatic test_combo();
      add(st(0, 1, 'h1, 0, 0, 0, 1),  ex(0, 0, 0, 0, 0, 0, 1, 0));
      add(st(0, 1, 'h3, 0, 0, 0, 1),  ex(1, 1, 0, 0, 0, 1, 1, 0));
      add(st(0, 1, 'h70, 0, 0, 0, 1), ex(1, 3, 0, 0, 0, 2, 1, 0));
      add(st(0, 1, 'hF00, 0, 0, 0, 1), ex(1, 5, 0, 0, 0, 3, 1, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1),  ex(0, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("combo", i); end
      end
      total++;
      if (lines_cleared !== 10'd20) begin bad++; $display("FAIL combo_lines_cleared: got %0d want 20", lines_cleared); end
      total++;
      if (lines_sent !== 10'd16) begin bad++; $display("FAIL combo_lines_sent: got %0d want 16", lines_sent); end
   endtask

   task automatic test_b2b();
      add(st(1, 0, 'h0, 0, 0, 0, 1),  ex(0, 0, 0, 0, 0, 0, 0, 0));
      add(st(0, 1, 'hF, 0, 0, 0, 1),  ex(1, 4, 0, 0, 0, 0, 1, 1));
      add(st(0, 1, 'hF0, 0, 0, 0, 1), ex(1, 5, 0, 0, 0, 1, 1, 1));
      add(st(0, 1, 'h3, 0, 0, 0, 1),  ex(1, 2, 0, 0, 0, 2, 1, 0));
      add(st(0, 1, 'h0, 0, 0, 0, 1),  ex(0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("b2b", i); end
      end
      total++;
      if (lines_sent !== 10'd11) begin bad++; $display("FAIL b2b_lines_sent: got %0d want 11", lines_sent); end
   endtask

   task automatic test_cancel();
      add(st(0, 0, 'h0, 0, 1, 3, 1), ex(0, 0, 3, 0, 0, 0, 0, 0));
      add(st(0, 1, 'hF, 0, 0, 0, 1), ex(1, 1, 0, 0, 0, 0, 1, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("cancel", i); end
      end
      total++;
      if (lines_sent !== 10'd12) begin bad++; $display("FAIL cancel_lines_sent: got %0d want 12", lines_sent); end
   endtask

   task automatic test_rise();
      add(st(0, 0, 'h0, 0, 1, 11, 1), ex(0, 0, 11, 0, 0, 0, 0, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1),  ex(0, 0, 3, 1, 8, 0, 0, 1));
      add(st(0, 0, 'h0, 0, 0, 0, 1),  ex(0, 0, 3, 0, 0, 0, 0, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1),  ex(0, 0, 0, 1, 3, 0, 0, 1));
      add(st(0, 0, 'h0, 0, 0, 0, 1),  ex(0, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("rise", i); end
      end
   endtask

   task automatic test_same_cycle_garbage();
      add(st(0, 1, 'h0, 0, 1, 2, 1),   ex(0, 0, 2, 0, 0, 0, 0, 1));
      add(st(0, 1, 'hF, 0, 1, 5, 1),   ex(1, 3, 5, 0, 0, 0, 1, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1),   ex(0, 0, 0, 1, 5, 0, 0, 1));
      add(st(0, 0, 'h0, 0, 1, 0, 1),   ex(0, 0, 0, 0, 0, 0, 0, 1));
      add(st(0, 0, 'h0, 0, 1, 20, 1),  ex(0, 0, 20, 0, 0, 0, 0, 1));
      add(st(0, 0, 'h0, 0, 1, 20, 1),  ex(0, 0, 31, 0, 0, 0, 0, 1));
      add(st(0, 1, 'h0, 0, 0, 0, 1),   ex(0, 0, 23, 1, 8, 0, 0, 1));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("same_cycle", i); end
      end
      total++;
      if (lines_cleared !== 10'd18) begin bad++; $display("FAIL same_cycle_lines_cleared: got %0d want 18", lines_cleared); end
      total++;
      if (lines_sent !== 10'd15) begin bad++; $display("FAIL same_cycle_lines_sent: got %0d want 15", lines_sent); end
   endtask

   task automatic test_back_to_back();
      add(st(1, 0, 'h0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
      add(st(0, 1, 'h3, 0, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, 1, 0));
      add(st(0, 1, 'h3, 0, 0, 0, 0), ex(1, 2, 0, 0, 0, 1, 1, 0));
      add(st(0, 0, 'h0, 0, 0, 0, 0), ex(1, 2, 0, 0, 0, 1, 1, 0));
      add(st(0, 0, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 1, 1, 0));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("back_to_back", i); end
      end
   endtask

   task automatic test_game_start();
      add(st(0, 0, 'h0, 0, 1, 2, 1), ex(0, 0, 2, 0, 0, 1, 1, 0));
      add(st(0, 1, 'hF, 0, 0, 0, 1), ex(1, 3, 0, 0, 0, 2, 1, 1));
      add(st(1, 1, 'hF, 0, 1, 5, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("game_start", i); end
      end
      total++;
      if (lines_cleared !== 10'd0) begin bad++; $display("FAIL game_start_lines_cleared: got %0d want 0", lines_cleared); end
      total++;
      if (lines_sent !== 10'd0) begin bad++; $display("FAIL game_start_lines_sent: got %0d want 0", lines_sent); end
   endtask

   task automatic test_tspin();
      add(st(1, 0, 'h0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef TSPIN_ATTACK_EN
      add(st(0, 1, 'h3, 1, 0, 0, 1), ex(1, 4, 0, 0, 0, 0, 1, 1));
`else
      add(st(0, 1, 'h3, 1, 0, 0, 1), ex(1, 1, 0, 0, 0, 0, 1, 0));
`endif
      for (int i = 0; stim_q.size() > 0; i++) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin bad++; show_fail("tspin", i); end
      end
   endtask

   initial begin
      test_reset();
      test_base_attack();
      test_combo();
      test_b2b();
      test_cancel();
      test_rise();
      test_same_cycle_garbage();
      test_back_to_back();
      test_game_start();
      test_tspin();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
